// File: rtl/lu_share_if.sv
// Request, response and logic-unit signals of the shared logic-unit controller.
// Handshake: a transfer occurs on a rising edge where valid and ready are both high; once
// raised, a response valid and its data stay stable until that transfer.
interface lu_share_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [SEL_W-1:0] req0_sel;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [SEL_W-1:0] req1_sel;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_data;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [SEL_W-1:0] lu_sel;
    logic [WIDTH-1:0] lu_out;
    logic             busy;
    logic [CNT_W-1:0] done_count;
    logic [1:0]       dbg_state;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp0_ready, rsp1_ready, lu_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output lu_a, lu_b, lu_sel, busy, done_count, dbg_state
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp0_ready, rsp1_ready, lu_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  lu_a, lu_b, lu_sel, busy, done_count, dbg_state
    );
endinterface

// File: rtl/lu_share_ctrl.sv
// Round-robin sharing of one combinational logic unit between two requesters:
// accept into registered operands, capture the result a cycle later, hold it until taken.
module lu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    lu_share_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lu_a_q;
    logic [WIDTH-1:0] lu_b_q;
    logic [SEL_W-1:0] lu_sel_q;
    logic [WIDTH-1:0] rsp0_data_q;
    logic [WIDTH-1:0] rsp1_data_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             cur_id_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] done_count_q;

    logic             grant_d;
    logic             any_valid_d;
    logic             rsp_ready_d;

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        any_valid_d = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = bus.req1_valid;
        end
        rsp_ready_d = cur_id_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = (state_q == IDLE) && !grant_d && bus.req0_valid;
    assign bus.req1_ready = (state_q == IDLE) &&  grant_d && bus.req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lu_a_q       <= '0;
            lu_b_q       <= '0;
            lu_sel_q     <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            cur_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid_d) begin
                        lu_a_q       <= grant_d ? bus.req1_a   : bus.req0_a;
                        lu_b_q       <= grant_d ? bus.req1_b   : bus.req0_b;
                        lu_sel_q     <= grant_d ? bus.req1_sel : bus.req0_sel;
                        cur_id_q     <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cur_id_q) begin
                        rsp1_data_q  <= bus.lu_out;
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rsp0_data_q  <= bus.lu_out;
                        rsp0_valid_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_d) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        if (done_count_q != {CNT_W{1'b1}}) begin
                            done_count_q <= done_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.lu_a       = lu_a_q;
    assign bus.lu_b       = lu_b_q;
    assign bus.lu_sel     = lu_sel_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done_count = done_count_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_lu_share_ctrl.sv
// Bench for lu_share_ctrl: directed scenarios plus randomized two-requester traffic,
// with a monitor that scores every accept and response against a reference model.
module tb_lu_share_ctrl;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lu_share_if #(.WIDTH(W), .SEL_W(S), .CNT_W(16)) bus ();
    lu_share_if #(.WIDTH(W), .SEL_W(S), .CNT_W(2))  bus2 ();

    lu_share_ctrl #(.WIDTH(W), .SEL_W(S), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    lu_share_ctrl #(.WIDTH(W), .SEL_W(S), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // The shared logic unit: a small fixed table of bitwise functions.
    function automatic logic [W-1:0] lu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [S-1:0] sel);
        case (sel)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return ~(a | b);
            4'd4:    return a & ~b;
            4'd5:    return ~(a & b);
            4'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    logic         r0_valid = 1'b0, r1_valid = 1'b0;
    logic [W-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [S-1:0] r0_sel = '0, r1_sel = '0;
    logic         rsp0_rdy = 1'b1, rsp1_rdy = 1'b1;
    logic         s_valid = 1'b0;

    assign bus.req0_valid = r0_valid;
    assign bus.req0_a     = r0_a;
    assign bus.req0_b     = r0_b;
    assign bus.req0_sel   = r0_sel;
    assign bus.req1_valid = r1_valid;
    assign bus.req1_a     = r1_a;
    assign bus.req1_b     = r1_b;
    assign bus.req1_sel   = r1_sel;
    assign bus.rsp0_ready = rsp0_rdy;
    assign bus.rsp1_ready = rsp1_rdy;
    assign bus.lu_out     = lu_f(bus.lu_a, bus.lu_b, bus.lu_sel);

    assign bus2.req0_valid = s_valid;
    assign bus2.req0_a     = 32'hA5A5_0000;
    assign bus2.req0_b     = 32'h0000_5A5A;
    assign bus2.req0_sel   = 4'd1;
    assign bus2.req1_valid = 1'b0;
    assign bus2.req1_a     = '0;
    assign bus2.req1_b     = '0;
    assign bus2.req1_sel   = '0;
    assign bus2.rsp0_ready = 1'b1;
    assign bus2.rsp1_ready = 1'b1;
    assign bus2.lu_out     = lu_f(bus2.lu_a, bus2.lu_b, bus2.lu_sel);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard state
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           acc_id[$];
    int           acc_cyc[$];
    int           cyc = 0;
    int           rise0 = -1, rise1 = -1;
    logic         pv0 = 1'b0, pv1 = 1'b0;
    logic         last_win = 1'b1;
    logic         win, exp_win;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            rise0 = -1;
            rise1 = -1;
            pv0 = 1'b0;
            pv1 = 1'b0;
            last_win = 1'b1;
        end else begin
            if (bus.req0_ready || bus.req1_ready) begin
                win = bus.req1_ready;
                check("single_ready", bus.req0_ready & bus.req1_ready, 0);
                exp_win = (bus.req0_valid && bus.req1_valid) ? ~last_win : bus.req1_valid;
                check("grant", win, exp_win);
                check("ready_needs_valid", win ? bus.req1_valid : bus.req0_valid, 1);
                last_win = win;
                acc_id.push_back(int'(win));
                acc_cyc.push_back(cyc);
                if (win) begin
                    exp_q1.push_back(lu_f(bus.req1_a, bus.req1_b, bus.req1_sel));
                    rise1 = cyc + 2;
                end else begin
                    exp_q0.push_back(lu_f(bus.req0_a, bus.req0_b, bus.req0_sel));
                    rise0 = cyc + 2;
                end
            end
            if (bus.rsp0_valid && !pv0) begin
                check("rsp0_latency", cyc, rise0);
                rise0 = -1;
            end
            if (bus.rsp1_valid && !pv1) begin
                check("rsp1_latency", cyc, rise1);
                rise1 = -1;
            end
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                check("rsp0_pending", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) check("rsp0_data", bus.rsp0_data, exp_q0.pop_front());
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                check("rsp1_pending", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0) check("rsp1_data", bus.rsp1_data, exp_q1.pop_front());
            end
            pv0 = bus.rsp0_valid;
            pv1 = bus.rsp1_valid;
        end
    end

    // Driver tasks
    task automatic set_req(input int id, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [S-1:0] sel);
        if (id == 0) begin
            r0_valid = v; r0_a = a; r0_b = b; r0_sel = sel;
        end else begin
            r1_valid = v; r1_a = a; r1_b = b; r1_sel = sel;
        end
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [S-1:0] sel, input bit patient);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        set_req(id, 1'b1, a, b, sel);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id == 0) ? bus.req0_ready : bus.req1_ready) begin
                acc = 1'b1;
                break;
            end
            if (!patient) break;
        end
        @(posedge clk);
        #1;
        if (id == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
        if (patient) check("issue_accepted", acc, 1);
    endtask

    task automatic rand_drv(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(id, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    bit           rand_done = 1'b0;
    bit           seen;
    logic [W-1:0] exp_d;

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_rsp0_data", bus.rsp0_data, 0);
        check("rst_lu_a", bus.lu_a, 0);
        check("rst_lu_sel", bus.lu_sel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done_count", bus.done_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single AND operation; operand changes right after accept must not matter
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0);
        @(negedge clk);
        check("single_ready", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        r0_a = 32'h1234_5678;
        @(negedge clk);
        check("single_lu_a", bus.lu_a, 32'hF0F0_F0F0);
        check("single_lu_b", bus.lu_b, 32'h0FF0_0FF0);
        check("single_busy", bus.busy, 1);
        @(negedge clk);
        check("single_rsp_valid", bus.rsp0_valid, 1);
        check("single_rsp_data", bus.rsp0_data, 32'h00F0_00F0);
        @(negedge clk);
        check("single_done_count", bus.done_count, 1);
        check("single_rsp_cleared", bus.rsp0_valid, 0);
        check("single_data_held", bus.rsp0_data, 32'h00F0_00F0);

        // Continuous contention from reset
        do_reset();
        acc_id.delete();
        acc_cyc.delete();
        set_req(0, 1'b1, 32'hCAFE_0001, 32'h0F0F_0F0F, 4'd2);
        set_req(1, 1'b1, 32'h1357_9BDF, 32'hFFFF_0000, 4'd4);
        for (int i = 0; i < 40 && acc_id.size() < 4; i++) @(negedge clk);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check("rr_accept_count", acc_id.size() >= 4, 1);
        if (acc_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", acc_id[i], i % 2);
            for (int i = 1; i < 4; i++) check("rr_interval", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        repeat (4) @(negedge clk);

        // Response back-pressure on requester 1
        rsp1_rdy = 1'b0;
        issue(1, 32'hDEAD_BEEF, 32'h00FF_00FF, 4'd1, 1'b1);
        exp_d = lu_f(32'hDEAD_BEEF, 32'h00FF_00FF, 4'd1);
        set_req(0, 1'b1, 32'h8888_7777, 32'h3333_CCCC, 4'd5);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp1_valid;
        end
        check("bp_rsp1_valid", seen, 1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_rsp1_data", bus.rsp1_data, exp_d);
            check("bp_req0_blocked", bus.req0_ready, 0);
            check("bp_busy", bus.busy, 1);
        end
        @(posedge clk);
        #1;
        rsp1_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_resume_ready", bus.req0_ready, 1);
        check("bp_resume_idle", bus.busy, 0);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset asserted during EXEC
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'd3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.req0_ready;
        end
        check("mid_accept", seen, 1);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        check("mid_in_exec", bus.dbg_state, 2'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", bus.busy, 0);
        check("mid_lu_a", bus.lu_a, 0);
        check("mid_rsp0_valid", bus.rsp0_valid, 0);
        check("mid_done_count", bus.done_count, 0);
        check("mid_rsp1_data", bus.rsp1_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 0);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 32'h1111_2222, 32'h3333_4444, 4'd6);
        set_req(1, 1'b1, 32'h5555_6666, 32'h7777_8888, 4'd7);
        @(negedge clk);
        check("mid_first_req0", bus.req0_ready, 1);
        check("mid_first_req1", bus.req1_ready, 0);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.req1_ready;
        end
        check("mid_second_req1", seen, 1);
        @(posedge clk);
        #1;
        r1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic with random response back-pressure
        fork
            begin
                fork
                    rand_drv(0, 30);
                    rand_drv(1, 30);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp0_rdy = $urandom_range(0, 3) != 0;
                    rsp1_rdy = $urandom_range(0, 3) != 0;
                end
            end
        join
        rsp0_rdy = 1'b1;
        rsp1_rdy = 1'b1;
        for (int i = 0; i < 20 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(negedge clk);
        check("drain", exp_q0.size() + exp_q1.size(), 0);

        // Saturating counter on the narrow-counter instance
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                seen = bus2.rsp0_valid;
            end
            check("sat_rsp_valid", seen, 1);
            @(posedge clk);
            #1;
            check("sat_done_count", bus2.done_count, (i < 3) ? (i + 1) : 3);
        end
        s_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
